// File: rtl/adc_axis_pkg.sv
// adc_axis_pkg: FSM states and beat field layout shared by the ADC stream receiver.
package adc_axis_pkg;
    typedef enum logic [1:0] {IDLE, SYNC, STREAM, DRAIN} state_t;
    localparam int CNT_MSB = 63;
    localparam int CNT_LSB = 32;
    localparam int I_MSB = 31;
    localparam int I_LSB = 16;
    localparam int Q_MSB = 15;
    localparam int Q_LSB = 0;
    localparam logic [7:0] KEEP_ALL = 8'hFF;
endpackage

// File: rtl/axis_skid_buffer_2.sv
// axis_skid_buffer_2: two-entry output buffer; full is a flop decode so upstream ready never sees out_ready.
module axis_skid_buffer_2 #(
    parameter int WIDTH = 65
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    logic [WIDTH-1:0] head, tail;
    logic [1:0] occ;
    logic pop;

    assign pop = out_valid && out_ready;
    assign out_valid = occ != 2'd0;
    assign out_data = head;
    assign full = occ == 2'd2;

    // push is only ever asserted while not full, so the tail never needs a bypass
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            head <= '0;
            tail <= '0;
            occ <= '0;
        end else begin
            if (pop) head <= (push && occ == 2'd1) ? push_data : tail;
            else if (push && occ == 2'd0) head <= push_data;
            if (push && occ == 2'd1 && !pop) tail <= push_data;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/adc_axis_rx.sv
// adc_axis_rx: unpacks {counter, I, Q} AXIS beats into samples, checking counter continuity and frame length.
module adc_axis_rx
    import adc_axis_pkg::*;
#(
    parameter int ADC_AXI_DATA_WIDTH = 64,
    parameter int ADC_AXI_TUSER_WIDTH = 1,
    parameter int FRAME_LEN_MAX = 8192,
    parameter int STAT_WIDTH = 16
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic [ADC_AXI_DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                           s_axis_tvalid,
    input  logic                           s_axis_tlast,
    input  logic [7:0]                     s_axis_tkeep,
    input  logic [ADC_AXI_TUSER_WIDTH-1:0] s_axis_tuser,
    output logic                           s_axis_tready,
    input  logic                           rx_enable,
    input  logic                           stat_clear,
    output logic [15:0]                    m_sample_i,
    output logic [15:0]                    m_sample_q,
    output logic [31:0]                    m_sample_cnt,
    output logic                           m_sample_valid,
    output logic                           m_sample_last,
    input  logic                           m_sample_ready,
    output logic [STAT_WIDTH-1:0]          frame_count,
    output logic [STAT_WIDTH-1:0]          gap_error_count,
    output logic [31:0]                    frame_len_last,
    output logic                           gap_error,
    output logic                           keep_error,
    output logic                           overlong_error,
    output logic                           rx_active
);
    localparam logic [STAT_WIDTH-1:0] ONE = 1;

    state_t state;
    logic full, accept, force_last, last_in, done, gap, keep_bad, unused_tuser;
    logic [31:0] cnt, expected, beats, n;
    logic [ADC_AXI_DATA_WIDTH:0] out_data;

    assign unused_tuser = ^s_axis_tuser;
    assign s_axis_tready = state != IDLE && !full;
    assign accept = s_axis_tvalid && s_axis_tready;
    assign cnt = s_axis_tdata[CNT_MSB:CNT_LSB];
    assign n = (state == SYNC) ? 32'd1 : beats + 32'd1;
    // the beat that reaches the length limit without tlast is closed as a forced last
    assign force_last = !s_axis_tlast && n == 32'(FRAME_LEN_MAX);
    assign last_in = s_axis_tlast || force_last;
    assign done = accept && last_in;
    assign gap = accept && state != SYNC && cnt != expected;
    assign keep_bad = accept && s_axis_tkeep != KEEP_ALL;
    assign rx_active = state != IDLE;

    assign m_sample_last = out_data[ADC_AXI_DATA_WIDTH];
    assign m_sample_cnt = out_data[CNT_MSB:CNT_LSB];
    assign m_sample_i = out_data[I_MSB:I_LSB];
    assign m_sample_q = out_data[Q_MSB:Q_LSB];

    axis_skid_buffer_2 #(.WIDTH(ADC_AXI_DATA_WIDTH + 1)) skid (
        .aclk,
        .areset,
        .push(accept),
        .push_data({last_in, s_axis_tdata}),
        .full,
        .out_data,
        .out_valid(m_sample_valid),
        .out_ready(m_sample_ready)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
            expected <= '0;
            beats <= '0;
        end else begin
            if (accept) begin
                expected <= cnt + 32'd1;
                beats <= n;
            end
            case (state)
                IDLE: if (rx_enable) state <= SYNC;
                SYNC: begin
                    if (done) state <= rx_enable ? SYNC : IDLE;
                    else if (accept) state <= rx_enable ? STREAM : DRAIN;
                    else if (!rx_enable) state <= IDLE;
                end
                STREAM: begin
                    if (done) state <= rx_enable ? SYNC : IDLE;
                    else if (!rx_enable) state <= DRAIN;
                end
                DRAIN: if (done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // a clear coinciding with an event leaves that event counted once
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            frame_count <= '0;
            gap_error_count <= '0;
            frame_len_last <= '0;
            gap_error <= 1'b0;
            keep_error <= 1'b0;
            overlong_error <= 1'b0;
        end else begin
            frame_count <= stat_clear ? (done ? ONE : '0) :
                           (done && frame_count != '1) ? frame_count + ONE : frame_count;
            gap_error_count <= stat_clear ? (gap ? ONE : '0) :
                               (gap && gap_error_count != '1) ? gap_error_count + ONE : gap_error_count;
            frame_len_last <= done ? n : stat_clear ? '0 : frame_len_last;
            gap_error <= gap || (gap_error && !stat_clear);
            keep_error <= keep_bad || (keep_error && !stat_clear);
            overlong_error <= (accept && force_last) || (overlong_error && !stat_clear);
        end
    end
endmodule

// File: tb/tb_adc_axis_rx.sv
// tb_adc_axis_rx: randomized and directed stimulus checked every cycle against a frame-level reference model.
module tb_adc_axis_rx;
    localparam int FLM = 72;
    localparam int SW = 4;
    localparam logic [SW-1:0] SMAX = '1;

    logic aclk = 1'b0, areset = 1'b1;
    logic [63:0] s_axis_tdata = '0;
    logic s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0;
    logic [7:0] s_axis_tkeep = 8'hFF;
    logic [0:0] s_axis_tuser = '0;
    logic s_axis_tready;
    logic rx_enable = 1'b0, stat_clear = 1'b0, m_sample_ready = 1'b1;
    logic [15:0] m_sample_i, m_sample_q;
    logic [31:0] m_sample_cnt, frame_len_last;
    logic m_sample_valid, m_sample_last;
    logic [SW-1:0] frame_count, gap_error_count;
    logic gap_error, keep_error, overlong_error, rx_active;

    int compared = 0, mismatched = 0;
    int ready_mode = 0;
    bit rand_ctl = 1'b0;
    bit saw_stall = 1'b0;
    logic [31:0] last_cnts[$];

    // reference model state
    logic [64:0] q[$];
    bit armed, in_frame, draining;
    logic [31:0] exp_cnt, beats, m_fll;
    logic [SW-1:0] m_fc, m_gc;
    bit m_ge, m_ke, m_oe;

    always #5 aclk = ~aclk;

    adc_axis_rx #(
        .ADC_AXI_DATA_WIDTH(64),
        .ADC_AXI_TUSER_WIDTH(1),
        .FRAME_LEN_MAX(FLM),
        .STAT_WIDTH(SW)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast),
        .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tuser(s_axis_tuser),
        .s_axis_tready(s_axis_tready),
        .rx_enable(rx_enable),
        .stat_clear(stat_clear),
        .m_sample_i(m_sample_i),
        .m_sample_q(m_sample_q),
        .m_sample_cnt(m_sample_cnt),
        .m_sample_valid(m_sample_valid),
        .m_sample_last(m_sample_last),
        .m_sample_ready(m_sample_ready),
        .frame_count(frame_count),
        .gap_error_count(gap_error_count),
        .frame_len_last(frame_len_last),
        .gap_error(gap_error),
        .keep_error(keep_error),
        .overlong_error(overlong_error),
        .rx_active(rx_active)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: samples inputs at each edge, applies the receiver's frame rules
    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            q.delete();
            armed = 0; in_frame = 0; draining = 0;
            exp_cnt = 0; beats = 0; m_fll = 0; m_fc = 0; m_gc = 0;
            m_ge = 0; m_ke = 0; m_oe = 0;
        end else begin
            bit acc, forced, lst, gp, kb;
            logic [31:0] c, n;
            acc = s_axis_tvalid && (armed || in_frame) && q.size() < 2;
            c = s_axis_tdata[63:32];
            n = armed ? 32'd1 : beats + 32'd1;
            forced = acc && !s_axis_tlast && n == FLM;
            lst = acc && (s_axis_tlast || forced);
            gp = acc && in_frame && c != exp_cnt;
            kb = acc && s_axis_tkeep != 8'hFF;
            if (q.size() > 0 && m_sample_ready) void'(q.pop_front());
            if (acc) begin
                q.push_back({s_axis_tlast || forced, s_axis_tdata});
                exp_cnt = c + 32'd1;
                beats = n;
            end
            if (stat_clear) begin
                m_fc = 0; m_gc = 0; m_fll = 0; m_ge = 0; m_ke = 0; m_oe = 0;
            end
            if (lst) begin
                m_fll = n;
                if (m_fc != SMAX) m_fc++;
            end
            if (gp) begin
                m_ge = 1;
                if (m_gc != SMAX) m_gc++;
            end
            if (kb) m_ke = 1;
            if (forced) m_oe = 1;
            if (!armed && !in_frame) armed = rx_enable;
            else if (armed) begin
                if (lst) armed = rx_enable;
                else if (acc) begin
                    armed = 0; in_frame = 1; draining = !rx_enable;
                end else armed = rx_enable;
            end else begin
                if (lst) begin
                    in_frame = 0; armed = rx_enable && !draining; draining = 0;
                end else if (!rx_enable) draining = 1;
            end
        end
    end

    always @(negedge aclk) begin
        if (areset) begin
            chk("reset_outputs", {s_axis_tready, m_sample_valid, m_sample_last, m_sample_cnt, m_sample_i,
                m_sample_q, frame_count, gap_error_count, frame_len_last, gap_error, keep_error,
                overlong_error, rx_active}, '0);
        end else begin
            chk("tready", 128'(s_axis_tready), 128'((armed || in_frame) && q.size() < 2));
            chk("valid", 128'(m_sample_valid), 128'(q.size() > 0));
            if (m_sample_valid && q.size() > 0)
                chk("sample", {m_sample_last, m_sample_cnt, m_sample_i, m_sample_q}, 128'(q[0]));
            chk("stats", {frame_count, gap_error_count, frame_len_last}, {m_fc, m_gc, m_fll});
            chk("flags", {gap_error, keep_error, overlong_error, rx_active},
                {m_ge, m_ke, m_oe, armed || in_frame});
            if (m_sample_valid && m_sample_ready && m_sample_last) last_cnts.push_back(m_sample_cnt);
            if (in_frame && !s_axis_tready && s_axis_tvalid) saw_stall = 1'b1;
        end
    end

    initial begin
        int rcyc = 0;
        forever begin
            @(posedge aclk);
            #1;
            rcyc++;
            m_sample_ready = (ready_mode == 0) ? 1'b1 :
                             (ready_mode == 1) ? ((rcyc / 3) % 2 == 0) :
                             (ready_mode == 2) ? ($urandom_range(0, 2) != 0) : 1'b0;
            if (rand_ctl) begin
                stat_clear = $urandom_range(0, 40) == 0;
                rx_enable = rx_enable ? ($urandom_range(0, 30) != 0) : ($urandom_range(0, 3) == 0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic send(input logic [31:0] c, input logic l, input logic [7:0] k);
        bit got;
        s_axis_tvalid = 1'b1;
        s_axis_tdata = {c, 16'($urandom), 16'($urandom)};
        s_axis_tlast = l;
        s_axis_tkeep = k;
        for (int t = 0; t < 300; t++) begin
            @(negedge aclk);
            got = s_axis_tready;
            @(posedge aclk);
            #1;
            if (got) return;
        end
        chk("send_timeout", 128'(1), 128'(0));
    endtask

    task automatic pulse_clear();
        stat_clear = 1'b1;
        idle(1);
        stat_clear = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 60 && q.size() > 0; t++) idle(1);
        chk("drain_empty", 128'(q.size()), 128'(0));
    endtask

    initial begin
        idle(2);
        areset = 1'b0;
        rx_enable = 1'b1;

        for (int k = 0; k < 64; k++) send(32'(100 + k), k == 63, 8'hFF);
        s_axis_tvalid = 1'b0;
        drain();
        chk("cont_frames", 128'(frame_count), 128'(1));
        chk("cont_len", 128'(frame_len_last), 128'(64));
        chk("cont_gaps", 128'(gap_error_count), 128'(0));

        pulse_clear();
        send(32'd10, 1'b0, 8'hFF); send(32'd11, 1'b0, 8'hFF);
        send(32'd13, 1'b0, 8'hFF); send(32'd14, 1'b1, 8'hFF);
        s_axis_tvalid = 1'b0;
        drain();
        chk("gap_count", 128'(gap_error_count), 128'(1));
        chk("gap_flag", 128'(gap_error), 128'(1));

        pulse_clear();
        send(32'hFFFF_FFFE, 1'b0, 8'hFF); send(32'hFFFF_FFFF, 1'b0, 8'hFF);
        send(32'h0, 1'b1, 8'hFF); send(32'h500, 1'b0, 8'hFF); send(32'h501, 1'b1, 8'hFF);
        s_axis_tvalid = 1'b0;
        drain();
        chk("wrap_gaps", 128'(gap_error_count), 128'(0));
        chk("wrap_frames", 128'(frame_count), 128'(2));

        ready_mode = 1;
        for (int k = 0; k < 30; k++) send(32'(2000 + k), k == 29, 8'hFF);
        s_axis_tvalid = 1'b0;
        ready_mode = 0;
        drain();
        chk("bp_stall_seen", 128'(saw_stall), 128'(1));

        pulse_clear();
        for (int k = 0; k < 40; k++) begin
            if (k == 20) rx_enable = 1'b0;
            send(32'(3000 + k), k == 39, 8'hFF);
        end
        s_axis_tvalid = 1'b0;
        idle(3);
        chk("drain_idle", 128'(rx_active), 128'(0));
        s_axis_tvalid = 1'b1;
        idle(2);
        chk("drain_tready", 128'(s_axis_tready), 128'(0));
        chk("drain_len", 128'(frame_len_last), 128'(40));
        s_axis_tvalid = 1'b0;
        rx_enable = 1'b1;

        pulse_clear();
        last_cnts.delete();
        for (int k = 0; k < 76; k++) send(32'(4000 + k), k == 75, (k == 4) ? 8'h0F : 8'hFF);
        s_axis_tvalid = 1'b0;
        drain();
        chk("ovl_flag", 128'(overlong_error), 128'(1));
        chk("ovl_keep", 128'(keep_error), 128'(1));
        chk("ovl_frames", 128'(frame_count), 128'(2));
        chk("ovl_len", 128'(frame_len_last), 128'(4));
        chk("ovl_lasts", 128'(last_cnts.size()), 128'(2));
        if (last_cnts.size() == 2) chk("ovl_forced_at", {last_cnts[0], last_cnts[1]}, {32'd4071, 32'd4075});
        pulse_clear();
        chk("clear_all", {frame_count, gap_error_count, frame_len_last, gap_error, keep_error, overlong_error}, '0);

        ready_mode = 3;
        send(32'd6000, 1'b0, 8'hFF);
        send(32'd6001, 1'b0, 8'hFF);
        s_axis_tvalid = 1'b0;
        idle(1);
        areset = 1'b1;
        idle(2);
        areset = 1'b0;
        ready_mode = 0;
        for (int k = 0; k < 4; k++) send(32'(9000 + k), k == 3, 8'hFF);
        s_axis_tvalid = 1'b0;
        drain();
        chk("rst_frames", 128'(frame_count), 128'(1));
        chk("rst_gaps", 128'(gap_error_count), 128'(0));

        rand_ctl = 1'b1;
        ready_mode = 2;
        for (int f = 0; f < 40; f++) begin
            logic [31:0] c;
            int len;
            c = $urandom;
            len = $urandom_range(1, 90);
            for (int k = 0; k < len; k++) begin
                send(c, k == len - 1, ($urandom_range(0, 29) == 0) ? 8'h7F : 8'hFF);
                c = c + (($urandom_range(0, 19) == 0) ? 32'd2 : 32'd1);
                if ($urandom_range(0, 4) == 0) begin
                    s_axis_tvalid = 1'b0;
                    idle($urandom_range(1, 3));
                end
            end
        end
        s_axis_tvalid = 1'b0;
        rand_ctl = 1'b0;
        stat_clear = 1'b0;
        rx_enable = 1'b1;
        ready_mode = 0;
        drain();
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "watchdog");
    end
endmodule
